// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI transaction engine between
// NUM_REQ requesters. Each grant launches one register read/write with a
// one-cycle spi_enable pulse. Completion is the rising edge of spi_done,
// followed by a GAP_CYCLES idle gap.
// Optional feature macro: SPI_ARB_TIMEOUT_EN. It aborts a transaction after
// TIMEOUT_CYCLES BUSY cycles without done and flags resp_err.
module spi_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_read,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [7:0]             resp_rdata,
  output logic                   resp_err,
  output logic                   busy,
  output logic [7:0]             spi_addr,
  output logic [7:0]             spi_wdata,
  output logic                   spi_read,
  output logic                   spi_enable,
  input  logic                   spi_done,
  input  logic [7:0]             spi_rdata
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [GW-1:0]   gap_cnt;
  logic            done_q;
  logic            done_edge;
  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic [7:0]      sel_addr;
  logic [7:0]      sel_wdata;
  logic            sel_read;
  logic            busy_done;
  logic            busy_tmo;

  assign done_edge = spi_done & ~done_q;
  assign busy_done = (state == BUSY) && done_edge;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  // Timeout fires on the last allowed BUSY cycle when no done edge arrived
  assign busy_tmo = (state == BUSY) && !done_edge && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // BUSY cycle counter, restarted on every entry to BUSY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != BUSY) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Error flag accompanies the response pulse only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else begin
      resp_err <= busy_tmo;
    end
  end
`else
  logic unused_tmo;
  assign busy_tmo   = 1'b0;
  assign resp_err   = 1'b0;
  assign unused_tmo = |TIMEOUT_CYCLES;
`endif

  // Round-robin search starting one past the last grant, with wrap-around
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((32'(ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the winning requester's transaction fields
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_read  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_addr  = req_addr[8*i +: 8];
        sel_wdata = req_wdata[8*i +: 8];
        sel_read  = req_read[i];
      end
    end
  end

  // Arbitration FSM with registered outputs; ptr doubles as the current grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= PW'(NUM_REQ - 1);
      gap_cnt    <= '0;
      done_q     <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      busy       <= 1'b0;
      spi_addr   <= '0;
      spi_wdata  <= '0;
      spi_read   <= 1'b0;
      spi_enable <= 1'b0;
    end else begin
      done_q     <= spi_done;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      spi_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            spi_addr   <= sel_addr;
            spi_wdata  <= sel_wdata;
            spi_read   <= sel_read;
            ptr        <= grant_idx;
            req_ready  <= NUM_REQ'(1) << grant_idx;
            spi_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= BUSY;
        end
        BUSY: begin
          if (busy_done || busy_tmo) begin
            resp_valid <= NUM_REQ'(1) << ptr;
            resp_rdata <= busy_done ? spi_rdata : 8'h00;
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed testbench for spi_bus_arbiter (NUM_REQ=2, GAP_CYCLES=2, TIMEOUT_CYCLES=16).
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_read;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [7:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_read;
  logic        spi_enable;
  logic        spi_done;
  logic [7:0]  spi_rdata;

  int errors = 0;
  int checks = 0;

  int en_cnt  = 0;
  int rdy_cnt0 = 0;
  int rdy_cnt1 = 0;
  int rv_cnt0 = 0;
  int rv_cnt1 = 0;

  spi_bus_arbiter #(
    .NUM_REQ(2),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_read(req_read),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .busy(busy),
    .spi_addr(spi_addr),
    .spi_wdata(spi_wdata),
    .spi_read(spi_read),
    .spi_enable(spi_enable),
    .spi_done(spi_done),
    .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (spi_enable === 1'b1) en_cnt++;
    if (req_ready[0] === 1'b1) rdy_cnt0++;
    if (req_ready[1] === 1'b1) rdy_cnt1++;
    if (resp_valid[0] === 1'b1) rv_cnt0++;
    if (resp_valid[1] === 1'b1) rv_cnt1++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (spi_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (spi_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", spi_enable); end
    checks++; if ({req_ready, resp_valid} !== 4'b0) begin errors++; $display("FAIL reset_handshake: got %b expected 0000", {req_ready, resp_valid}); end
    checks++; if ({spi_addr, spi_wdata, spi_read, resp_rdata, resp_err} !== 26'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {spi_addr, spi_wdata, spi_read, resp_rdata, resp_err});
    end
    reset = 1'b0;
    repeat (4) step();
    checks++; if (busy !== 1'b0 || en_cnt != 0) begin errors++; $display("FAIL idle_no_req: busy=%b enables=%0d expected 0/0", busy, en_cnt); end
  endtask

  task automatic test_read;
    int e0, r0, v0;
    bit ok;
    e0 = en_cnt; r0 = rdy_cnt0; v0 = rv_cnt0;
    req_read  = 2'b01;
    req_addr  = 16'h000F;
    req_valid = 2'b01;
    wait_enable(ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_enable: got no spi_enable expected one"); end
    checks++; if (spi_addr !== 8'h0F || spi_read !== 1'b1) begin errors++; $display("FAIL read_cmd: got addr=%h read=%b expected 0f/1", spi_addr, spi_read); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL read_ready: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    repeat (20) step();
    spi_rdata = 8'h6A;
    spi_done  = 1'b1;
    checks++; if (busy !== 1'b1 || resp_valid !== 2'b00) begin errors++; $display("FAIL read_pending: got busy=%b resp=%b expected 1/00", busy, resp_valid); end
    step();
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 8'h6A || resp_err !== 1'b0) begin
      errors++; $display("FAIL read_resp: got v=%b d=%h e=%b expected 01/6a/0", resp_valid, resp_rdata, resp_err);
    end
    spi_done = 1'b0;
    step();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL read_resp_pulse: got %b expected 00", resp_valid); end
    step();
    checks++; if (en_cnt - e0 != 1 || rdy_cnt0 - r0 != 1 || rv_cnt0 - v0 != 1) begin
      errors++; $display("FAIL read_pulses: got en=%0d rdy=%0d rv=%0d expected 1/1/1", en_cnt - e0, rdy_cnt0 - r0, rv_cnt0 - v0);
    end
  endtask

  task automatic test_write;
    int v0, v1;
    bit ok;
    v0 = rv_cnt0; v1 = rv_cnt1;
    req_read  = 2'b00;
    req_addr  = 16'h1000;
    req_wdata = 16'h5000;
    req_valid = 2'b10;
    wait_enable(ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_enable: got no spi_enable expected one"); end
    checks++; if (spi_read !== 1'b0 || spi_wdata !== 8'h50 || spi_addr !== 8'h10) begin
      errors++; $display("FAIL write_cmd: got read=%b wd=%h addr=%h expected 0/50/10", spi_read, spi_wdata, spi_addr);
    end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL write_ready: got %b expected 10", req_ready); end
    req_valid = 2'b00;
    repeat (4) step();
    spi_rdata = 8'h99;
    spi_done  = 1'b1;
    step();
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL write_resp: got %b expected 10", resp_valid); end
    spi_done = 1'b0;
    repeat (2) step();
    checks++; if (rv_cnt0 - v0 != 0 || rv_cnt1 - v1 != 1) begin
      errors++; $display("FAIL write_resp_count: got rv0=%0d rv1=%0d expected 0/1", rv_cnt0 - v0, rv_cnt1 - v1);
    end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_g [0:3];
    logic [7:0] exp_a [0:3];
    int e0;
    bit ok;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a = '{8'h21, 8'h22, 8'h21, 8'h22};
    reset = 1'b1;
    step();
    reset = 1'b0;
    e0 = en_cnt;
    req_read  = 2'b11;
    req_addr  = 16'h2221;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_enable(ok);
      checks++; if (!ok || req_ready !== exp_g[i] || spi_addr !== exp_a[i]) begin
        errors++; $display("FAIL arb_grant%0d: got ok=%b ready=%b addr=%h expected 1/%b/%h", i, ok, req_ready, spi_addr, exp_g[i], exp_a[i]);
      end
      if (i == 3) req_valid = 2'b00;
      repeat (3) step();
      spi_done = 1'b1;
      step();
      checks++; if (resp_valid !== exp_g[i]) begin errors++; $display("FAIL arb_resp%0d: got %b expected %b", i, resp_valid, exp_g[i]); end
      spi_done = 1'b0;
    end
    repeat (8) step();
    checks++; if (en_cnt - e0 != 4) begin errors++; $display("FAIL arb_enable_count: got %0d expected 4", en_cnt - e0); end
  endtask

  task automatic test_gap;
    int n, vt;
    bit ok;
    req_read  = 2'b11;
    req_addr  = 16'h3231;
    req_valid = 2'b11;
    wait_enable(ok);
    checks++; if (!ok || req_ready !== 2'b01) begin errors++; $display("FAIL gap_first_grant: got ok=%b ready=%b expected 1/01", ok, req_ready); end
    repeat (2) step();
    spi_rdata = 8'h11;
    spi_done  = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) begin
        checks++; if (resp_valid !== 2'b01 || resp_rdata !== 8'h11) begin
          errors++; $display("FAIL gap_resp: got v=%b d=%h expected 01/11", resp_valid, resp_rdata);
        end
      end
      if (spi_enable === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL gap_spacing: got %0d cycles expected 4", n); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL gap_second_grant: got %b expected 10", req_ready); end
    req_valid = 2'b00;
    vt = rv_cnt0 + rv_cnt1;
    repeat (10) step();
    checks++; if (busy !== 1'b1 || rv_cnt0 + rv_cnt1 != vt) begin
      errors++; $display("FAIL gap_stale_done: got busy=%b resps=%0d expected 1/0", busy, rv_cnt0 + rv_cnt1 - vt);
    end
    spi_done = 1'b0;
    step();
    spi_done  = 1'b1;
    spi_rdata = 8'h22;
    step();
    checks++; if (resp_valid !== 2'b10 || resp_rdata !== 8'h22) begin
      errors++; $display("FAIL gap_second_resp: got v=%b d=%h expected 10/22", resp_valid, resp_rdata);
    end
    spi_done = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid;
    int vt;
    bit ok;
    req_read  = 2'b01;
    req_addr  = 16'h3433;
    req_valid = 2'b01;
    wait_enable(ok);
    #2 reset = 1'b1;
    #1;
    checks++; if (!ok || spi_enable !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_issue: got ok=%b en=%b rdy=%b busy=%b expected 1/0/00/0", ok, spi_enable, req_ready, busy);
    end
    #1 reset = 1'b0;
    wait_enable(ok);
    repeat (2) step();
    checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL reset_busy_pre: got ok=%b busy=%b expected 1/1", ok, busy); end
    vt = rv_cnt0 + rv_cnt1;
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || spi_enable !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL reset_mid_busy: got busy=%b en=%b rdy=%b rv=%b expected 0/0/00/00", busy, spi_enable, req_ready, resp_valid);
    end
    step();
    reset = 1'b0;
    req_valid = 2'b11;
    wait_enable(ok);
    checks++; if (!ok || req_ready !== 2'b01) begin errors++; $display("FAIL reset_regrant: got ok=%b ready=%b expected 1/01", ok, req_ready); end
    checks++; if (rv_cnt0 + rv_cnt1 != vt) begin errors++; $display("FAIL reset_dropped: got %0d resps expected 0", rv_cnt0 + rv_cnt1 - vt); end
    req_valid = 2'b00;
    repeat (2) step();
    spi_done = 1'b1;
    step();
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL reset_after_resp: got %b expected 01", resp_valid); end
    spi_done = 1'b0;
    repeat (4) step();
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int vt;
    bit ok;
    req_read  = 2'b01;
    req_addr  = 16'h0044;
    req_valid = 2'b01;
    spi_rdata = 8'hAB;
    spi_done  = 1'b0;
    wait_enable(ok);
    req_valid = 2'b00;
    repeat (16) step();
    checks++; if (!ok || resp_valid !== 2'b00) begin errors++; $display("FAIL tmo_early: got ok=%b rv=%b expected 1/00", ok, resp_valid); end
    step();
    checks++; if (resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_rdata !== 8'h00) begin
      errors++; $display("FAIL tmo_resp: got v=%b e=%b d=%h expected 01/1/00", resp_valid, resp_err, resp_rdata);
    end
    step();
    vt = rv_cnt0 + rv_cnt1;
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    repeat (6) step();
    checks++; if (rv_cnt0 + rv_cnt1 != vt || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_late_done: got resps=%0d busy=%b expected 0/0", rv_cnt0 + rv_cnt1 - vt, busy);
    end
    req_read  = 2'b00;
    req_valid = 2'b10;
    wait_enable(ok);
    checks++; if (!ok || req_ready !== 2'b10) begin errors++; $display("FAIL tmo_next_grant: got ok=%b ready=%b expected 1/10", ok, req_ready); end
    req_valid = 2'b00;
    repeat (2) step();
    spi_rdata = 8'h5C;
    spi_done  = 1'b1;
    step();
    checks++; if (resp_valid !== 2'b10 || resp_err !== 1'b0 || resp_rdata !== 8'h5C) begin
      errors++; $display("FAIL tmo_next_resp: got v=%b e=%b d=%h expected 10/0/5c", resp_valid, resp_err, resp_rdata);
    end
    spi_done = 1'b0;
    repeat (2) step();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_read  = 2'b00;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    spi_done  = 1'b0;
    spi_rdata = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_gap();
    test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single SPI transaction engine between NUM_REQ independent requesters, for example the IMU poller and a configuration writer.
- Each request is one 8-bit-address transaction: register read or register write.
- Arbitration is round-robin; transactions are strictly serialized.
- Each transaction is launched with a one-cycle enable pulse to the SPI engine.
- Completion is taken from the rising edge of the engine's done signal.
- A programmable idle gap between transactions keeps CS deasserted between frames.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
GAP_CYCLES, 2, idle cycles after each completion before the next grant (0 allowed)
TIMEOUT_CYCLES, 4096, BUSY cycles without done before abort (only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  NUM_REQ  request pending per requester; held until req_ready
req_read  in  NUM_REQ  1=read, 0=write, per requester
req_addr  in  8*NUM_REQ  requester i at [8i+7:8i]
req_wdata  in  8*NUM_REQ  write data, same packing
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
resp_rdata  out  8  read data, valid with resp_valid
resp_err  out  1  timeout flag, valid with resp_valid
busy  out  1  high in any state other than IDLE
spi_addr  out  8  to SPI engine
spi_wdata  out  8  to SPI engine
spi_read  out  1  to SPI engine
spi_enable  out  1  one-cycle start pulse to SPI engine
spi_done  in  1  from SPI engine; a rising edge marks completion
spi_rdata  in  8  from SPI engine

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = NUM_REQ-1, so requester 0 wins first; done edge register 0.
- Registered FSM with states IDLE, ISSUE, BUSY, GAP.
- IDLE:
  - req_valid is sampled only in IDLE.
  - If any bit is set, grant g = first set index searching from pointer+1 with wrap-around.
  - Latch req_addr/req_wdata/req_read of g into spi_addr/spi_wdata/spi_read.
  - Set pointer = g; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle): req_ready[g]=1 and spi_enable=1; go to BUSY.
- spi_addr, spi_wdata and spi_read stay stable from ISSUE until the next grant.
- BUSY:
  - done_edge = spi_done & ~done_q, where done_q is spi_done registered every cycle in all states.
  - A spi_done level still high from the previous transaction is not an edge.
  - On done_edge in cycle e: capture spi_rdata; go to GAP (or to IDLE if GAP_CYCLES=0).
- Response: resp_valid[g]=1, resp_rdata and resp_err are driven in cycle e+1 only.
- The read data capture also occurs for writes; requesters ignore it.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
  - The next spi_enable occurs no earlier than cycle e+GAP_CYCLES+2.
- Requester timing:
  - A requester that drops req_valid before its grant is simply skipped.
  - A requester may re-request in the cycle after its resp_valid.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...
- A spi_done edge in IDLE, ISSUE or GAP is ignored.
- Reset mid-operation returns to IDLE immediately. Any in-flight request is dropped with no resp_valid; the requester must re-issue it.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A BUSY cycle counter is cleared on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES without done_edge, the FSM leaves BUSY as on completion.
  - That cycle's response carries resp_err=1 and resp_rdata=8'h00.
  - A late done edge is ignored.
- Undefined:
  - No counter is built; BUSY waits indefinitely.
  - resp_err is tied to 0.

Test Plan:
- Read: req0 read addr 8'h0F, model raises done 20 cycles after enable with rdata 8'h6A -> one req_ready[0] pulse; one spi_enable pulse with spi_addr=0x0F, spi_read=1; resp_valid[0] one cycle after the done edge with resp_rdata=0x6A, resp_err=0.
- Write: req1 write addr 8'h10 wdata 8'h50 -> spi_read=0, spi_wdata=0x50; resp_valid[1] pulse; resp_valid[0] stays 0.
- Arbitration: req0 and req1 valid together from reset, each re-requesting immediately -> grant order 0,1,0,1 over 4 transactions; exactly one spi_enable per transaction.
- Gap timing: GAP_CYCLES=2, both requests pending -> next spi_enable exactly 4 cycles after the cycle done first reads high; a stale high done at the second enable does not complete the second transaction.
- Reset: assert reset mid-BUSY -> spi_enable, busy, req_ready and resp_valid drop to 0 without a clock edge; after release with both valid, req0 is granted first.
- Timeout: SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, done never rises -> resp_valid[g] with resp_err=1 and rdata 8'h00 after 16 BUSY cycles; the next request proceeds normally.
